fibonacci_core: RTL and testbench

- Fibonacci sequence generator that sits directly downstream of the Wishbone control block.
- Consumes the control block's `clock_op` and `switch_out` outputs.
- Drives the generated value onto the user IO bus at `io_out[37:8]`. The control block reads that bus back as the Fibonacci value register.
- Advances one term every `clock_op` cycles while enabled, and wraps to `F0` when the next term no longer fits the output width.

---
 rtl/fibonacci_core.sv | 104 ++++++++++
 tb/tb_fibonacci_core.sv | 311 +++++++++++++++++++++++++++++++
 2 files changed

// File: rtl/fibonacci_core.sv
// ============================================================================
// Module   : fibonacci_core
// Function : Fibonacci term generator that advances once every clock_op
//            enabled clocks and drives the current term onto the user IO bus.
// Revision : 1.0 - initial release
// ============================================================================
`default_nettype none

module fibonacci_core #(
  parameter int CLOCK_WIDTH = 6,
  parameter int VALUE_WIDTH = 30,
  parameter int IO_PADS     = 38,
  parameter int INDEX_WIDTH = 8
) (
  input  logic                   wb_clk_i,
  input  logic                   reset_n,
  input  logic                   enable,
  input  logic [CLOCK_WIDTH-1:0] clock_op,
  input  logic                   restart,
  output logic [VALUE_WIDTH-1:0] fib_o,
  output logic [INDEX_WIDTH-1:0] index_o,
  output logic                   step_o,
  output logic                   wrap_o,
  output logic [IO_PADS-1:0]     io_out,
  output logic [IO_PADS-1:0]     io_oeb
);

  logic [VALUE_WIDTH-1:0] r_cur;
  logic [VALUE_WIDTH:0]   r_nxt;
  logic [CLOCK_WIDTH-1:0] r_div_cnt;
  logic [INDEX_WIDTH-1:0] r_index;
  logic                   r_step;
  logic                   r_wrap;

  logic                   w_run;
  logic [CLOCK_WIDTH:0]   w_cnt_inc;
  logic                   w_tick;
  logic [VALUE_WIDTH:0]   w_sum;

  // Compare one bit wider so div_cnt+1 never wraps and a lowered clock_op
  // always yields a tick instead of a lockup.
  assign w_run     = enable && (clock_op != '0);
  assign w_cnt_inc = {1'b0, r_div_cnt} + (CLOCK_WIDTH+1)'(1);
  assign w_tick    = w_run && (w_cnt_inc >= {1'b0, clock_op});
  assign w_sum     = {1'b0, r_cur} + r_nxt;

  always_ff @(posedge wb_clk_i or negedge reset_n) begin
    if (!reset_n) begin
      r_cur     <= '0;
      r_nxt     <= (VALUE_WIDTH+1)'(1);
      r_div_cnt <= '0;
      r_index   <= '0;
      r_step    <= 1'b0;
      r_wrap    <= 1'b0;
    end else if (restart) begin
      r_cur     <= '0;
      r_nxt     <= (VALUE_WIDTH+1)'(1);
      r_div_cnt <= '0;
      r_index   <= '0;
      r_step    <= 1'b0;
      r_wrap    <= 1'b0;
    end else begin
      r_step <= 1'b0;
      r_wrap <= 1'b0;
      if (!enable) begin
        r_div_cnt <= '0;
      end else if (w_tick) begin
        r_div_cnt <= '0;
        r_step    <= 1'b1;
        if (r_nxt[VALUE_WIDTH]) begin
          r_cur   <= '0;
          r_nxt   <= (VALUE_WIDTH+1)'(1);
          r_index <= '0;
          r_wrap  <= 1'b1;
        end else begin
          r_cur   <= r_nxt[VALUE_WIDTH-1:0];
          r_nxt   <= w_sum;
          r_index <= r_index + INDEX_WIDTH'(1);
        end
      end else if (w_run) begin
        r_div_cnt <= w_cnt_inc[CLOCK_WIDTH-1:0];
      end
    end
  end

  assign fib_o   = r_cur;
  assign index_o = r_index;
  assign step_o  = r_step;
  assign wrap_o  = r_wrap;

  // The term occupies the top pads; any remaining low pads are inputs.
  generate
    if (IO_PADS > VALUE_WIDTH) begin : g_pad_split
      assign io_out = {fib_o, {(IO_PADS-VALUE_WIDTH){1'b0}}};
      assign io_oeb = {{VALUE_WIDTH{1'b0}}, {(IO_PADS-VALUE_WIDTH){1'b1}}};
    end else begin : g_pad_full
      assign io_out = fib_o;
      assign io_oeb = '0;
    end
  endgenerate

endmodule

`default_nettype wire

// File: tb/tb_fibonacci_core.sv
// ============================================================================
// Module   : tb_fibonacci_core
// Function : Scoreboard bench for fibonacci_core using an index-based term
//            table as the reference.
// Revision : 1.0 - initial release
// ============================================================================
`default_nettype none

module tb_fibonacci_core;

  logic        clk = 1'b0;
  logic        reset_n;
  logic        enable;
  logic [5:0]  clock_op;
  logic        restart;
  logic [29:0] fib_o;
  logic [7:0]  index_o;
  logic        step_o;
  logic        wrap_o;
  logic [37:0] io_out;
  logic [37:0] io_oeb;

  fibonacci_core dut (
    .wb_clk_i (clk),
    .reset_n  (reset_n),
    .enable   (enable),
    .clock_op (clock_op),
    .restart  (restart),
    .fib_o    (fib_o),
    .index_o  (index_o),
    .step_o   (step_o),
    .wrap_o   (wrap_o),
    .io_out   (io_out),
    .io_oeb   (io_oeb)
  );

  always #5 clk = ~clk;

  typedef struct {
    logic [29:0] fib;
    logic [7:0]  idx;
    logic        step;
    logic        wrap;
  } exp_t;

  exp_t    q[$];
  longint  tab[0:44];
  int      m_idx;
  int      m_div;
  int      total;
  int      bad;
  int      steps_seen;

  // One clock: drive inputs, predict, then compare after the edge.
  task automatic cycle(input logic en, input int cop, input logic rs);
    exp_t e;
    exp_t g;
    enable   = en;
    clock_op = 6'(cop);
    restart  = rs;
    e.step = 1'b0;
    e.wrap = 1'b0;
    if (rs) begin
      m_idx = 0;
      m_div = 0;
    end else if (!en) begin
      m_div = 0;
    end else if (cop != 0) begin
      if (m_div + 1 >= cop) begin
        m_div  = 0;
        e.step = 1'b1;
        if (m_idx == 44) begin
          m_idx  = 0;
          e.wrap = 1'b1;
        end else begin
          m_idx++;
        end
      end else begin
        m_div++;
      end
    end
    e.fib = tab[m_idx][29:0];
    e.idx = 8'(m_idx);
    q.push_back(e);
    @(posedge clk);
    #1;
    restart = 1'b0;
    total++;
    if (q.size() == 0) begin
      bad++;
      $display("FAIL scoreboard_empty: got queue size 0, need 1");
    end else begin
      g = q.pop_front();
      if (step_o) steps_seen++;
      if (fib_o !== g.fib) begin
        bad++;
        $display("FAIL fib_o: got %0d, need %0d (t=%0t)", fib_o, g.fib, $time);
      end
      total++;
      if (index_o !== g.idx) begin
        bad++;
        $display("FAIL index_o: got %0d, need %0d (t=%0t)", index_o, g.idx, $time);
      end
      total++;
      if (step_o !== g.step) begin
        bad++;
        $display("FAIL step_o: got %0b, need %0b (t=%0t)", step_o, g.step, $time);
      end
      total++;
      if (wrap_o !== g.wrap) begin
        bad++;
        $display("FAIL wrap_o: got %0b, need %0b (t=%0t)", wrap_o, g.wrap, $time);
      end
      total++;
      if (io_out !== {g.fib, 8'h00}) begin
        bad++;
        $display("FAIL io_out: got %h, need %h (t=%0t)", io_out, {g.fib, 8'h00}, $time);
      end
    end
  endtask

  task automatic test_reset();
    reset_n  = 1'b0;
    enable   = 1'b0;
    clock_op = 6'd0;
    restart  = 1'b0;
    repeat (3) @(posedge clk);
    #1;
    reset_n = 1'b1;
    m_idx = 0;
    m_div = 0;
    repeat (3) cycle(1'b0, 0, 1'b0);
    total++;
    if (io_oeb !== 38'h00000000FF) begin
      bad++;
      $display("FAIL io_oeb: got %h, need %h", io_oeb, 38'h00000000FF);
    end
    total++;
    if (fib_o !== 30'd0 || io_out !== 38'd0) begin
      bad++;
      $display("FAIL reset_values: got fib=%0d io=%h, need 0", fib_o, io_out);
    end
  endtask

  task automatic test_run();
    int want[10] = '{1, 1, 2, 3, 5, 8, 13, 21, 34, 55};
    for (int i = 0; i < 10; i++) begin
      cycle(1'b1, 1, 1'b0);
      total++;
      if (fib_o !== 30'(want[i]) || step_o !== 1'b1) begin
        bad++;
        $display("FAIL run_seq[%0d]: got fib=%0d step=%0b, need fib=%0d step=1",
                 i, fib_o, step_o, want[i]);
      end
    end
    total++;
    if (index_o !== 8'd10 || io_out[37:8] !== 30'd55) begin
      bad++;
      $display("FAIL run_end: got idx=%0d io=%0d, need idx=10 io=55", index_o, io_out[37:8]);
    end
  endtask

  task automatic test_divider();
    logic [29:0] held;
    cycle(1'b1, 3, 1'b1);
    steps_seen = 0;
    for (int i = 1; i <= 9; i++) cycle(1'b1, 3, 1'b0);
    total++;
    if (steps_seen != 3) begin
      bad++;
      $display("FAIL div3_steps: got %0d, need 3", steps_seen);
    end
    held = fib_o;
    steps_seen = 0;
    repeat (6) cycle(1'b1, 0, 1'b0);
    total++;
    if (steps_seen != 0 || fib_o !== held) begin
      bad++;
      $display("FAIL div0_frozen: got steps=%0d fib=%0d, need steps=0 fib=%0d",
               steps_seen, fib_o, held);
    end
    steps_seen = 0;
    repeat (6) cycle(1'b1, 2, 1'b0);
    total++;
    if (steps_seen != 3) begin
      bad++;
      $display("FAIL div2_steps: got %0d, need 3", steps_seen);
    end
    // Lowering clock_op below the running count must tick right away.
    cycle(1'b1, 20, 1'b1);
    repeat (5) cycle(1'b1, 20, 1'b0);
    cycle(1'b1, 2, 1'b0);
  endtask

  task automatic test_enable();
    int seen_at;
    cycle(1'b1, 1, 1'b1);
    repeat (5) cycle(1'b1, 1, 1'b0);
    repeat (20) cycle(1'b0, 1, 1'b0);
    total++;
    if (fib_o !== 30'd5 || index_o !== 8'd5) begin
      bad++;
      $display("FAIL enable_hold: got fib=%0d idx=%0d, need fib=5 idx=5", fib_o, index_o);
    end
    seen_at = 0;
    for (int i = 1; i <= 8 && seen_at == 0; i++) begin
      cycle(1'b1, 4, 1'b0);
      if (step_o) seen_at = i;
    end
    total++;
    if (seen_at != 4 || fib_o !== 30'd8) begin
      bad++;
      $display("FAIL enable_resume: got step at %0d fib=%0d, need step at 4 fib=8",
               seen_at, fib_o);
    end
  endtask

  task automatic test_wrap();
    cycle(1'b1, 1, 1'b1);
    repeat (44) cycle(1'b1, 1, 1'b0);
    total++;
    if (fib_o !== 30'd701408733 || index_o !== 8'd44) begin
      bad++;
      $display("FAIL wrap_peak: got fib=%0d idx=%0d, need 701408733/44", fib_o, index_o);
    end
    cycle(1'b1, 1, 1'b0);
    total++;
    if (fib_o !== 30'd0 || index_o !== 8'd0 || wrap_o !== 1'b1 || step_o !== 1'b1) begin
      bad++;
      $display("FAIL wrap_edge: got fib=%0d idx=%0d wrap=%0b step=%0b, need 0/0/1/1",
               fib_o, index_o, wrap_o, step_o);
    end
    cycle(1'b1, 1, 1'b0);
    total++;
    if (fib_o !== 30'd1 || wrap_o !== 1'b0) begin
      bad++;
      $display("FAIL wrap_after: got fib=%0d wrap=%0b, need 1/0", fib_o, wrap_o);
    end
  endtask

  task automatic test_restart();
    cycle(1'b1, 1, 1'b1);
    repeat (12) cycle(1'b1, 1, 1'b0);
    cycle(1'b1, 1, 1'b1);
    total++;
    if (fib_o !== 30'd0 || index_o !== 8'd0 || step_o !== 1'b0) begin
      bad++;
      $display("FAIL restart_prio: got fib=%0d idx=%0d step=%0b, need 0/0/0",
               fib_o, index_o, step_o);
    end
    cycle(1'b1, 1, 1'b0);
    total++;
    if (fib_o !== 30'd1 || index_o !== 8'd1) begin
      bad++;
      $display("FAIL restart_next: got fib=%0d idx=%0d, need 1/1", fib_o, index_o);
    end
    // Restart while disabled still reloads.
    repeat (4) cycle(1'b1, 1, 1'b0);
    cycle(1'b0, 0, 1'b1);
  endtask

  task automatic test_async_reset();
    cycle(1'b1, 3, 1'b1);
    repeat (7) cycle(1'b1, 1, 1'b0);
    #2;
    reset_n = 1'b0;
    #1;
    total++;
    if (fib_o !== 30'd0 || index_o !== 8'd0 || step_o !== 1'b0 ||
        wrap_o !== 1'b0 || io_out !== 38'd0) begin
      bad++;
      $display("FAIL async_reset: got fib=%0d idx=%0d step=%0b wrap=%0b io=%h, need all 0",
               fib_o, index_o, step_o, wrap_o, io_out);
    end
    @(posedge clk);
    #1;
    reset_n = 1'b1;
    m_idx = 0;
    m_div = 0;
    repeat (2) cycle(1'b1, 2, 1'b0);
    // Reset in the middle of a divide discards the partial count.
    cycle(1'b1, 3, 1'b0);
    reset_n = 1'b0;
    #2;
    reset_n = 1'b1;
    m_div = 0;
    m_idx = 0;
    repeat (4) cycle(1'b1, 3, 1'b0);
  endtask

  initial begin
    total = 0;
    bad   = 0;
    steps_seen = 0;
    tab[0] = 0;
    tab[1] = 1;
    for (int i = 2; i <= 44; i++) tab[i] = tab[i-1] + tab[i-2];
    test_reset();
    test_run();
    test_divider();
    test_enable();
    test_wrap();
    test_restart();
    test_async_reset();
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule

`default_nettype wire
